// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB endpoint protocol controller.
package usb_pkg;

  localparam int BUF_DEPTH_DEFAULT      = 64;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA  = 3'd3,
    PID_ACK   = 3'd4,
    PID_NAK   = 3'd5,
    PID_STALL = 3'd6
  } pid_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_RX   = 2'd2,
    OWN_TX   = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    HREQ_DATA  = 2'd0,
    HREQ_ACK   = 2'd1,
    HREQ_NAK   = 2'd2,
    HREQ_STALL = 2'd3
  } host_req_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_RX_DATA     = 2'd1,
    ST_TX_SEND     = 2'd2,
    ST_TX_WAIT_ACK = 2'd3
  } proto_state_t;

  function automatic pid_t host_req_to_pid(input host_req_t req);
    case (req)
      HREQ_ACK:   return PID_ACK;
      HREQ_NAK:   return PID_NAK;
      HREQ_STALL: return PID_STALL;
      default:    return PID_DATA;
    endcase
  endfunction

endpackage

// File: rtl/proto_timeout_timer.sv
// Saturating cycle counter with clear/enable; expired is high while the count
// sits at TIMEOUT_CYCLES. Only instantiated when USB_PROTO_TIMEOUT_EN is defined.
module proto_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB endpoint protocol controller: arbitrates data-buffer ownership and sequences
// RX/TX handshakes. Define USB_PROTO_TIMEOUT_EN to enable the packet-wait timeout.
module usb_protocol_ctrl
  import usb_pkg::*;
#(
  parameter int BUF_DEPTH      = BUF_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  localparam int OCC_W         = $clog2(BUF_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       rx_packet,
  input  logic             rx_packet_valid,
  input  logic             rx_error,
  input  logic             tx_transfer_active,
  input  logic             tx_error,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             host_tx_req,
  input  logic [1:0]       host_tx_packet,
  input  logic             host_clear_err,
  output logic             d_mode,
  output logic [2:0]       tx_packet,
  output logic             tx_start,
  output logic             clear_buffer,
  output logic [1:0]       buf_owner,
  output logic             rx_data_ready,
  output logic             tx_done,
  output logic             xfer_error,
  output logic             busy
);

  if (BUF_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("usb_protocol_ctrl: BUF_DEPTH and TIMEOUT_CYCLES must be positive");
  end

  proto_state_t state, state_n;
  pid_t         tx_pid, tx_pid_n;
  pid_t         rx_pid;
  pid_t         pend_pid;
  owner_t       owner_n;
  logic         tx_seen_active, tx_seen_active_n;
  logic         tx_armed, armed_clr;
  logic         pend_valid, pend_take;
  logic         tx_start_n, clear_buffer_n, tx_done_n, rx_data_ready_n;
  logic         d_mode_n, busy_n, err_set;
  logic         timeout_hit;

  assign rx_pid = pid_t'(rx_packet);

`ifdef USB_PROTO_TIMEOUT_EN
  logic timer_clear, timer_enable;

  // Reloads on every state change so each wait starts counting from zero.
  assign timer_clear  = (state_n != state);
  assign timer_enable = (state == ST_RX_DATA) || (state == ST_TX_WAIT_ACK);

  proto_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n          = state;
    tx_pid_n         = tx_pid;
    tx_seen_active_n = tx_seen_active;
    tx_start_n       = 1'b0;
    clear_buffer_n   = 1'b0;
    tx_done_n        = 1'b0;
    err_set          = 1'b0;
    armed_clr        = 1'b0;
    pend_take        = 1'b0;
    rx_data_ready_n  = rx_data_ready && !host_tx_req;

    case (state)
      ST_IDLE: begin
        if (rx_packet_valid && rx_pid == PID_OUT) begin
          state_n         = ST_RX_DATA;
          clear_buffer_n  = 1'b1;
          rx_data_ready_n = 1'b0;
        end else if (rx_packet_valid && rx_pid == PID_IN) begin
          state_n  = ST_TX_SEND;
          tx_pid_n = (tx_armed && buffer_occupancy != '0) ? PID_DATA : PID_NAK;
        end else if (pend_valid) begin
          state_n   = ST_TX_SEND;
          tx_pid_n  = pend_pid;
          pend_take = 1'b1;
        end
      end

      ST_RX_DATA: begin
        if (rx_error) begin
          state_n        = ST_TX_SEND;
          tx_pid_n       = PID_NAK;
          clear_buffer_n = 1'b1;
          err_set        = 1'b1;
        end else if (rx_packet_valid) begin
          if (rx_pid == PID_DATA && buffer_occupancy <= OCC_W'(BUF_DEPTH)) begin
            state_n         = ST_TX_SEND;
            tx_pid_n        = PID_ACK;
            rx_data_ready_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
            err_set = 1'b1;
          end
        end else if (timeout_hit) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
        end
      end

      ST_TX_SEND: begin
        // Completion is the falling edge of tx_transfer_active after it was seen high.
        if (tx_error) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
        end else if (!tx_seen_active) begin
          tx_seen_active_n = tx_transfer_active;
        end else if (!tx_transfer_active) begin
          state_n = (tx_pid == PID_DATA) ? ST_TX_WAIT_ACK : ST_IDLE;
        end
      end

      ST_TX_WAIT_ACK: begin
        if (rx_packet_valid) begin
          state_n = ST_IDLE;
          if (rx_pid == PID_ACK) begin
            clear_buffer_n = 1'b1;
            tx_done_n      = 1'b1;
            armed_clr      = 1'b1;
          end else if (rx_pid != PID_NAK) begin
            err_set = 1'b1;
          end
        end else if (rx_error) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
        end else if (timeout_hit) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_TX_SEND && state != ST_TX_SEND) begin
      tx_start_n       = 1'b1;
      tx_seen_active_n = 1'b0;
    end

    case (state_n)
      ST_RX_DATA:     owner_n = OWN_RX;
      ST_TX_SEND:     owner_n = OWN_TX;
      ST_TX_WAIT_ACK: owner_n = OWN_RX;
      default:        owner_n = OWN_HOST;
    endcase
    d_mode_n = (state_n == ST_TX_SEND);
    busy_n   = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state          <= ST_IDLE;
      tx_pid         <= PID_NONE;
      tx_seen_active <= 1'b0;
      tx_armed       <= 1'b0;
      pend_valid     <= 1'b0;
      pend_pid       <= PID_NONE;
      d_mode         <= 1'b0;
      tx_start       <= 1'b0;
      clear_buffer   <= 1'b0;
      buf_owner      <= OWN_HOST;
      rx_data_ready  <= 1'b0;
      tx_done        <= 1'b0;
      xfer_error     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      tx_pid         <= tx_pid_n;
      tx_seen_active <= tx_seen_active_n;
      d_mode         <= d_mode_n;
      tx_start       <= tx_start_n;
      clear_buffer   <= clear_buffer_n;
      buf_owner      <= owner_n;
      rx_data_ready  <= rx_data_ready_n;
      tx_done        <= tx_done_n;
      busy           <= busy_n;

      // A fresh DATA request wins over a same-cycle ACK clearing the arm.
      if (host_tx_req && host_tx_packet == HREQ_DATA) begin
        tx_armed <= 1'b1;
      end else if (armed_clr) begin
        tx_armed <= 1'b0;
      end

      if (host_tx_req && host_tx_packet != HREQ_DATA) begin
        pend_valid <= 1'b1;
        pend_pid   <= host_req_to_pid(host_req_t'(host_tx_packet));
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end

      if (err_set) begin
        xfer_error <= 1'b1;
      end else if (host_clear_err) begin
        xfer_error <= 1'b0;
      end
    end
  end

  assign tx_packet = tx_pid;

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Self-checking bench for usb_protocol_ctrl: randomized transactions checked against
// a transaction-level model; the timeout scenario adapts to USB_PROTO_TIMEOUT_EN.
module tb_usb_protocol_ctrl;

  localparam logic [2:0] P_NONE = 3'd0, P_OUT = 3'd1, P_IN = 3'd2, P_DATA = 3'd3;
  localparam logic [2:0] P_ACK = 3'd4, P_NAK = 3'd5, P_STALL = 3'd6;
  localparam logic [1:0] H_DATA = 2'd0, H_ACK = 2'd1, H_NAK = 2'd2, H_STALL = 2'd3;
  localparam logic [1:0] O_HOST = 2'd1, O_RX = 2'd2, O_TX = 2'd3;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 1024;

  logic       tb_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] rx_packet = '0;
  logic       rx_packet_valid = 1'b0, rx_error = 1'b0;
  logic       tx_transfer_active = 1'b0, tx_error = 1'b0;
  logic [6:0] buffer_occupancy = '0;
  logic       host_tx_req = 1'b0;
  logic [1:0] host_tx_packet = '0;
  logic       host_clear_err = 1'b0;
  logic       d_mode, tx_start, clear_buffer, rx_data_ready, tx_done, xfer_error, busy;
  logic [2:0] tx_packet;
  logic [1:0] buf_owner;

  int checks = 0;
  int passed = 0;

  // Transaction-level model of the controller's persistent flags.
  bit         m_armed, m_ready, m_err;

  usb_protocol_ctrl dut (
    .clk                (tb_clk),
    .n_rst              (n_rst),
    .rx_packet          (rx_packet),
    .rx_packet_valid    (rx_packet_valid),
    .rx_error           (rx_error),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .buffer_occupancy   (buffer_occupancy),
    .host_tx_req        (host_tx_req),
    .host_tx_packet     (host_tx_packet),
    .host_clear_err     (host_clear_err),
    .d_mode             (d_mode),
    .tx_packet          (tx_packet),
    .tx_start           (tx_start),
    .clear_buffer       (clear_buffer),
    .buf_owner          (buf_owner),
    .rx_data_ready      (rx_data_ready),
    .tx_done            (tx_done),
    .xfer_error         (xfer_error),
    .busy               (busy)
  );

  always #5 tb_clk = ~tb_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic rx_pkt(input logic [2:0] pid);
    rx_packet = pid;
    rx_packet_valid = 1'b1;
    step();
    rx_packet_valid = 1'b0;
    rx_packet = P_NONE;
  endtask

  task automatic host_req(input logic [1:0] p);
    host_tx_req = 1'b1;
    host_tx_packet = p;
    step();
    host_tx_req = 1'b0;
    host_tx_packet = H_DATA;
    if (p == H_DATA) m_armed = 1'b1;
    m_ready = 1'b0;
  endtask

  task automatic clear_err();
    host_clear_err = 1'b1;
    step();
    host_clear_err = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic run_tx(input int len);
    tx_transfer_active = 1'b1;
    repeat (len) step();
    tx_transfer_active = 1'b0;
    step();
  endtask

  function automatic logic [2:0] in_reply(input logic [6:0] occ);
    return (m_armed && occ != 0) ? P_DATA : P_NAK;
  endfunction

  function automatic logic [2:0] hreq_pid(input logic [1:0] p);
    return (p == H_ACK) ? P_ACK : (p == H_NAK) ? P_NAK : P_STALL;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) step();
    checks++; if (buf_owner !== O_HOST) $display("FAIL reset_owner: got %0d want %0d", buf_owner, O_HOST); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    checks++;
    if ({d_mode, tx_start, clear_buffer, rx_data_ready, tx_done, xfer_error, tx_packet} !== 9'd0)
      $display("FAIL reset_outputs: got %b want 0", {d_mode, tx_start, clear_buffer, rx_data_ready, tx_done, xfer_error, tx_packet});
    else passed++;
    n_rst = 1'b1;
    m_armed = 0; m_ready = 0; m_err = 0;
    step();
  endtask

  task automatic test_out_data();
    logic [6:0] occ;
    occ = 7'($urandom_range(DEPTH, 1));
    rx_pkt(P_OUT);
    m_ready = 1'b0;
    checks++; if (clear_buffer !== 1'b1) $display("FAIL out_clear: got %0b want 1", clear_buffer); else passed++;
    checks++; if (buf_owner !== O_RX) $display("FAIL out_owner: got %0d want %0d", buf_owner, O_RX); else passed++;
    step();
    checks++; if (clear_buffer !== 1'b0) $display("FAIL out_clear_pulse: got %0b want 0", clear_buffer); else passed++;
    buffer_occupancy = occ;
    rx_pkt(P_DATA);
    checks++; if (tx_start !== 1'b1 || tx_packet !== P_ACK) $display("FAIL data_ack_start: got start=%0b pid=%0d want 1/%0d", tx_start, tx_packet, P_ACK); else passed++;
    checks++; if (d_mode !== 1'b1 || buf_owner !== O_TX) $display("FAIL data_ack_dmode: got d=%0b own=%0d want 1/%0d", d_mode, buf_owner, O_TX); else passed++;
    step();
    checks++; if (tx_start !== 1'b0) $display("FAIL tx_start_pulse: got %0b want 0", tx_start); else passed++;
    run_tx($urandom_range(20, 3));
    m_ready = 1'b1;
    checks++; if (rx_data_ready !== m_ready) $display("FAIL rx_ready_set: got %0b want %0b", rx_data_ready, m_ready); else passed++;
    checks++; if (busy !== 1'b0 || d_mode !== 1'b0 || buf_owner !== O_HOST) $display("FAIL ack_to_idle: got busy=%0b d=%0b own=%0d want 0/0/%0d", busy, d_mode, buf_owner, O_HOST); else passed++;
  endtask

  task automatic test_in_data_ack();
    host_req(H_DATA);
    checks++; if (rx_data_ready !== m_ready) $display("FAIL rx_ready_host_clear: got %0b want %0b", rx_data_ready, m_ready); else passed++;
    buffer_occupancy = 7'd16;
    rx_pkt(P_IN);
    checks++; if (tx_packet !== in_reply(7'd16) || buf_owner !== O_TX) $display("FAIL in_data_pid: got pid=%0d own=%0d want %0d/%0d", tx_packet, buf_owner, in_reply(7'd16), O_TX); else passed++;
    run_tx(20);
    checks++; if (buf_owner !== O_RX || d_mode !== 1'b0 || busy !== 1'b1) $display("FAIL wait_ack_owner: got own=%0d d=%0b busy=%0b want %0d/0/1", buf_owner, d_mode, busy, O_RX); else passed++;
    rx_pkt(P_ACK);
    m_armed = 1'b0;
    checks++; if (tx_done !== 1'b1 || clear_buffer !== 1'b1 || busy !== 1'b0) $display("FAIL ack_done: got done=%0b clr=%0b busy=%0b want 1/1/0", tx_done, clear_buffer, busy); else passed++;
    step();
    checks++; if (tx_done !== 1'b0) $display("FAIL tx_done_pulse: got %0b want 0", tx_done); else passed++;
  endtask

  task automatic test_in_random();
    for (int i = 0; i < 8; i++) begin
      logic [6:0] occ;
      logic [2:0] exp_pid;
      if ($urandom_range(1, 0) == 1) host_req(H_DATA);
      occ = ($urandom_range(2, 0) == 0) ? 7'd0 : 7'($urandom_range(DEPTH, 1));
      buffer_occupancy = occ;
      exp_pid = in_reply(occ);
      rx_pkt(P_IN);
      checks++; if (tx_packet !== exp_pid || tx_start !== 1'b1) $display("FAIL in_rand_pid[%0d]: got pid=%0d start=%0b want %0d/1", i, tx_packet, tx_start, exp_pid); else passed++;
      run_tx($urandom_range(12, 1));
      if (exp_pid == P_DATA) begin
        checks++; if (buf_owner !== O_RX) $display("FAIL in_rand_wait[%0d]: got own=%0d want %0d", i, buf_owner, O_RX); else passed++;
        if ($urandom_range(1, 0) == 1) begin
          rx_pkt(P_ACK);
          m_armed = 1'b0;
          checks++; if (tx_done !== 1'b1) $display("FAIL in_rand_ack[%0d]: got %0b want 1", i, tx_done); else passed++;
        end else begin
          rx_pkt(P_NAK);
          checks++; if (tx_done !== 1'b0 || xfer_error !== m_err) $display("FAIL in_rand_nak[%0d]: got done=%0b err=%0b want 0/%0b", i, tx_done, xfer_error, m_err); else passed++;
        end
      end
      checks++; if (busy !== 1'b0 || buf_owner !== O_HOST) $display("FAIL in_rand_idle[%0d]: got busy=%0b own=%0d want 0/%0d", i, busy, buf_owner, O_HOST); else passed++;
    end
  endtask

  task automatic test_timeout();
    host_req(H_DATA);
    buffer_occupancy = 7'($urandom_range(DEPTH, 1));
    rx_pkt(P_IN);
    run_tx($urandom_range(8, 2));
`ifdef USB_PROTO_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < TIMEOUT + 100) begin
        step();
        n++;
      end
      checks++; if (n != TIMEOUT + 1) $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT + 1); else passed++;
    end
`else
    repeat (TIMEOUT + 76) step();
    checks++; if (busy !== 1'b1 || buf_owner !== O_RX) $display("FAIL no_timeout_wait: got busy=%0b own=%0d want 1/%0d", busy, buf_owner, O_RX); else passed++;
    rx_pkt(P_NAK);
`endif
    checks++; if (busy !== 1'b0 || xfer_error !== m_err) $display("FAIL timeout_idle: got busy=%0b err=%0b want 0/%0b", busy, xfer_error, m_err); else passed++;
    rx_pkt(P_IN);
    checks++; if (tx_packet !== in_reply(buffer_occupancy)) $display("FAIL retransmit_pid: got %0d want %0d", tx_packet, in_reply(buffer_occupancy)); else passed++;
    run_tx(4);
    rx_pkt(P_ACK);
    m_armed = 1'b0;
  endtask

  task automatic test_rx_error();
    rx_pkt(P_OUT);
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    m_err = 1'b1;
    checks++; if (tx_packet !== P_NAK || tx_start !== 1'b1 || clear_buffer !== 1'b1) $display("FAIL rxerr_nak: got pid=%0d start=%0b clr=%0b want %0d/1/1", tx_packet, tx_start, clear_buffer, P_NAK); else passed++;
    checks++; if (xfer_error !== m_err) $display("FAIL rxerr_flag: got %0b want %0b", xfer_error, m_err); else passed++;
    run_tx($urandom_range(10, 2));
    clear_err();
    checks++; if (xfer_error !== m_err) $display("FAIL err_clear: got %0b want %0b", xfer_error, m_err); else passed++;
    // Set and clear in the same cycle: the set must win.
    rx_pkt(P_OUT);
    host_clear_err = 1'b1;
    rx_pkt(P_ACK);
    host_clear_err = 1'b0;
    m_err = 1'b1;
    checks++; if (xfer_error !== m_err || busy !== 1'b0) $display("FAIL err_precedence: got err=%0b busy=%0b want %0b/0", xfer_error, busy, m_err); else passed++;
    clear_err();
    rx_pkt(P_OUT);
    buffer_occupancy = 7'(DEPTH);
    rx_pkt(P_DATA);
    checks++; if (tx_packet !== P_ACK || xfer_error !== 1'b0) $display("FAIL occ_full_ack: got pid=%0d err=%0b want %0d/0", tx_packet, xfer_error, P_ACK); else passed++;
    run_tx(3);
    rx_pkt(P_OUT);
    buffer_occupancy = 7'($urandom_range(127, DEPTH + 1));
    rx_pkt(P_DATA);
    m_err = 1'b1;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || xfer_error !== m_err) $display("FAIL occ_over: got busy=%0b start=%0b err=%0b want 0/0/1", busy, tx_start, xfer_error); else passed++;
    clear_err();
  endtask

  task automatic test_tx_error();
    host_req(H_DATA);
    buffer_occupancy = 7'($urandom_range(DEPTH, 1));
    rx_pkt(P_IN);
    tx_transfer_active = 1'b1;
    step();
    tx_error = 1'b1;
    step();
    tx_error = 1'b0;
    tx_transfer_active = 1'b0;
    m_err = 1'b1;
    checks++; if (d_mode !== 1'b0 || busy !== 1'b0 || xfer_error !== m_err) $display("FAIL tx_error: got d=%0b busy=%0b err=%0b want 0/0/1", d_mode, busy, xfer_error); else passed++;
    clear_err();
    rx_pkt(P_IN);
    checks++; if (tx_packet !== in_reply(buffer_occupancy)) $display("FAIL tx_error_rearm: got %0d want %0d", tx_packet, in_reply(buffer_occupancy)); else passed++;
    run_tx(2);
    rx_pkt(P_ACK);
    m_armed = 1'b0;
  endtask

  task automatic test_pending();
    logic [1:0] first, second;
    first  = 2'($urandom_range(3, 1));
    second = 2'($urandom_range(3, 1));
    rx_pkt(P_OUT);
    host_req(first);
    host_req(second);
    buffer_occupancy = 7'($urandom_range(DEPTH, 1));
    rx_pkt(P_DATA);
    m_ready = 1'b1;
    run_tx(3);
    checks++; if (busy !== 1'b0 || rx_data_ready !== m_ready) $display("FAIL pend_idle: got busy=%0b rdy=%0b want 0/%0b", busy, rx_data_ready, m_ready); else passed++;
    step();
    checks++; if (tx_start !== 1'b1 || tx_packet !== hreq_pid(second)) $display("FAIL pend_served: got start=%0b pid=%0d want 1/%0d", tx_start, tx_packet, hreq_pid(second)); else passed++;
    run_tx(2);
    step();
    checks++; if (busy !== 1'b0) $display("FAIL pend_consumed: got busy=%0b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    host_req(H_DATA);
    buffer_occupancy = 7'd10;
    rx_pkt(P_IN);
    tx_transfer_active = 1'b1;
    repeat (2) step();
    n_rst = 1'b0;
    step();
    checks++; if (d_mode !== 1'b0 || buf_owner !== O_HOST || busy !== 1'b0) $display("FAIL reset_mid: got d=%0b own=%0d busy=%0b want 0/%0d/0", d_mode, buf_owner, busy, O_HOST); else passed++;
    n_rst = 1'b1;
    tx_transfer_active = 1'b0;
    m_armed = 0; m_ready = 0; m_err = 0;
    step();
    rx_pkt(P_IN);
    checks++; if (tx_packet !== in_reply(7'd10)) $display("FAIL reset_disarm: got %0d want %0d", tx_packet, in_reply(7'd10)); else passed++;
    run_tx(2);
    checks++; if (busy !== 1'b0) $display("FAIL reset_nak_idle: got %0b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_out_data();
    test_in_data_ack();
    test_in_random();
    test_timeout();
    test_rx_error();
    test_tx_error();
    test_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/usb_protocol_ctrl.md
Name: usb_protocol_ctrl

Overview:
- Protocol controller that sequences the USB endpoint datapath inside overall_cdl.
- Decides who owns the shared 64-byte data buffer at any time: the AHB host side, USB RX or USB TX.
- Drives d_mode and tx_packet/tx_start to the USB TX, and reports rx/tx status back to the AHB slave status registers.
- Sits between the AHB-lite slave, the USB RX, the USB TX and the data buffer.

Parameters:
- BUF_DEPTH, 64, data buffer capacity in bytes; occupancy width is $clog2(BUF_DEPTH)+1.
- TIMEOUT_CYCLES, 1024, clk cycles to wait for a DATA or handshake packet before abandoning the transfer.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; synchronous, active-low.
- rx_packet  in  3  PID decoded by RX: 0 NONE, 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK; valid only with rx_packet_valid.
- rx_packet_valid  in  1  one-cycle strobe, end of a received packet.
- rx_error  in  1  one-cycle strobe, received packet was corrupt.
- tx_transfer_active  in  1  level, high while TX is serialising.
- tx_error  in  1  one-cycle strobe, TX failure.
- buffer_occupancy  in  7  current byte count in the data buffer.
- host_tx_req  in  1  one-cycle strobe from the AHB slave.
- host_tx_packet  in  2  0 DATA, 1 ACK, 2 NAK, 3 STALL; sampled with host_tx_req.
- host_clear_err  in  1  one-cycle strobe; clears xfer_error.
- d_mode  out  1  1 = TX drives the USB lines.
- tx_packet  out  3  PID for TX, same encoding as rx_packet.
- tx_start  out  1  one-cycle strobe telling TX to begin.
- clear_buffer  out  1  one-cycle strobe that empties the buffer.
- buf_owner  out  2  0 NONE, 1 HOST, 2 RX, 3 TX.
- rx_data_ready  out  1  level; an accepted OUT payload is in the buffer.
- tx_done  out  1  one-cycle strobe; IN data was ACKed.
- xfer_error  out  1  sticky error flag.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, taken synchronously on clk when n_rst=0:
  - state=IDLE, tx_armed=0, pending host request cleared, timer=0.
  - All outputs 0 except buf_owner=HOST.
- Outputs are registered: one-cycle latency from any input to its effect.
- IDLE: buf_owner=HOST, d_mode=0. Priority order:
  1. rx_packet_valid && OUT → RX_DATA; pulse clear_buffer; clear rx_data_ready.
  2. rx_packet_valid && IN → TX_SEND with DATA if tx_armed && occupancy>0, otherwise NAK.
  3. Pending ACK/NAK/STALL host request → TX_SEND with that PID.
- host_tx_req with DATA, in any state: sets tx_armed.
- host_tx_req with any other PID: stored in a one-deep pending slot; a newer request overwrites it; served in IDLE.
- RX_DATA: buf_owner=RX; timer runs.
  - DATA with occupancy ≤ BUF_DEPTH → TX_SEND(ACK); set rx_data_ready on entry.
  - rx_error → TX_SEND(NAK); pulse clear_buffer; set xfer_error.
  - Any other PID, or timer == TIMEOUT_CYCLES → IDLE; set xfer_error.
- TX_SEND: buf_owner=TX, d_mode=1; tx_start pulses in the first cycle only.
  - Waits for tx_transfer_active to rise, then fall.
  - After a DATA send → TX_WAIT_ACK; otherwise → IDLE.
  - tx_error → IDLE; set xfer_error; d_mode drops the next cycle.
- TX_WAIT_ACK: buf_owner=RX, d_mode=0; timer runs.
  - ACK → pulse clear_buffer and tx_done; clear tx_armed; → IDLE.
  - NAK or timeout → IDLE with tx_armed kept, so the next IN retransmits.
  - Any other PID → IDLE; set xfer_error.
- rx_data_ready clears on host_tx_req (any PID) or on the next OUT.
- Error precedence: xfer_error set and host_clear_err in the same cycle → xfer_error stays 1.
- Timer: reloads to 0 on every state entry; saturates at TIMEOUT_CYCLES.
- Reset asserted mid-transfer: d_mode falls on the reset edge; the buffer is not cleared by this block.

Optional Feature:
- Macro: USB_PROTO_TIMEOUT_EN.
- Defined: timer present; timeout transitions exactly as described above.
- Undefined: no timer logic; RX_DATA and TX_WAIT_ACK wait indefinitely and leave only on a packet or an error.

Decomposition:
- usb_pkg (shared):
  - pid_t enum (NONE, OUT, IN, DATA, ACK, NAK, STALL=6).
  - owner_t enum.
  - host_req_t enum.
  - proto_state_t enum (IDLE, RX_DATA, TX_SEND, TX_WAIT_ACK).
  - BUF_DEPTH default.
- Sub-module proto_timeout_timer: clear/enable saturating counter with a terminal flag; instantiated only under USB_PROTO_TIMEOUT_EN.

Test Plan:
- OUT strobe, then DATA strobe with occupancy=8 → clear_buffer 1 cycle after OUT; tx_start with tx_packet=ACK, d_mode=1; rx_data_ready=1 after tx_transfer_active falls.
- host DATA req with occupancy=16, then IN, TX active 20 cycles, then ACK → tx_packet=DATA; buf_owner TX→RX; tx_done and clear_buffer pulse; busy=0.
- IN with tx_armed=0 → tx_packet=NAK; after TX completes the FSM returns to IDLE, never TX_WAIT_ACK.
- Armed IN, then no reply for 1024 cycles (macro on) → IDLE at cycle 1025; tx_armed still 1; a second IN resends DATA.
- OUT, then rx_error → NAK sent, clear_buffer pulse, xfer_error=1; host_clear_err → xfer_error=0.
- n_rst=0 during TX_SEND → next edge: d_mode=0, buf_owner=HOST, busy=0, tx_armed=0.
